matrix_mac_engine: RTL

MATRIX_MAC_ENGINE -- requirements
Module: matrix_mac_engine

---
 rtl/matrix_pkg.sv | 28 ++
 rtl/mac_unit.sv | 24 ++
 rtl/matrix_mac_engine.sv | 133 +++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and step-to-element index helpers for the 2x2 MAC engine.
package matrix_pkg;

   localparam int unsigned ELEM_W = 32;
   localparam int unsigned N      = 2;
   localparam int unsigned NELEM  = N * N;
   localparam int unsigned STEP_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Step s = {e[1], e[0], k} with i = e[1], j = e[0]; elements are stored row-major.
   function automatic logic [1:0] a_idx(input logic [STEP_W-1:0] s);
      return {s[2], s[0]};
   endfunction

   function automatic logic [1:0] b_idx(input logic [STEP_W-1:0] s);
      return {s[0], s[1]};
   endfunction

   function automatic logic [1:0] c_idx(input logic [STEP_W-1:0] s);
      return s[2:1];
   endfunction

endpackage

// File: rtl/mac_unit.sv
// Combinational multiply-accumulate: sum = acc + a*b modulo 2^ELEM_W, flagging any lost bits.
module mac_unit #(
   parameter int unsigned ELEM_W = 32
) (
   input  logic [ELEM_W-1:0] a_i,
   input  logic [ELEM_W-1:0] b_i,
   input  logic [ELEM_W-1:0] acc_i,
   output logic [ELEM_W-1:0] sum_c_o,
   output logic              ovf_c_o
);

   localparam int unsigned PROD_W = 2 * ELEM_W;

   logic [PROD_W-1:0] prod_c;
   logic [ELEM_W:0]   add_c;

   always_comb begin
      prod_c  = PROD_W'(a_i) * PROD_W'(b_i);
      add_c   = {1'b0, acc_i} + {1'b0, prod_c[ELEM_W-1:0]};
      sum_c_o = add_c[ELEM_W-1:0];
      ovf_c_o = (|prod_c[PROD_W-1:ELEM_W]) | add_c[ELEM_W];
   end

endmodule

// File: rtl/matrix_mac_engine.sv
// Sequential 2x2 matrix multiplier: one product per cycle through a shared MAC, result committed at once.
module matrix_mac_engine #(
   parameter int unsigned ELEM_W = matrix_pkg::ELEM_W
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     start,
   input  logic [matrix_pkg::NELEM*ELEM_W-1:0]      a_data,
   input  logic [matrix_pkg::NELEM*ELEM_W-1:0]      b_data,
   input  logic                                     a_busy,
   input  logic                                     b_busy,
   output logic [matrix_pkg::NELEM*ELEM_W-1:0]      c_data,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     overflow
);

   import matrix_pkg::*;

   localparam int unsigned MAT_W = NELEM * ELEM_W;

   state_e              state_q, state_d;
   logic [MAT_W-1:0]    a_q, a_d, b_q, b_d;
   logic [MAT_W-1:0]    res_q, res_d, c_q, c_d;
   logic [ELEM_W-1:0]   acc_q, acc_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic                flush_q, flush_d;
   logic                ovf_q, ovf_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [ELEM_W-1:0]   mac_a_c, mac_b_c, sum_c;
   logic                ovf_c;

   assign mac_a_c = a_q[ELEM_W*32'(a_idx(step_q)) +: ELEM_W];
   assign mac_b_c = b_q[ELEM_W*32'(b_idx(step_q)) +: ELEM_W];

   mac_unit #(.ELEM_W(ELEM_W)) u_mac (
      .a_i     (mac_a_c),
      .b_i     (mac_b_c),
      .acc_i   (acc_q),
      .sum_c_o (sum_c),
      .ovf_c_o (ovf_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         c_q     <= '0;
         acc_q   <= '0;
         step_q  <= '0;
         flush_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         c_q     <= c_d;
         acc_q   <= acc_d;
         step_q  <= step_d;
         flush_q <= flush_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Partial sums land in res_q; the extra flush cycle after step 7 copies all four elements to c_q together.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      c_d     = c_q;
      acc_d   = acc_q;
      step_d  = step_q;
      flush_d = flush_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE: begin
            if (start && !a_busy && !b_busy) begin
               a_d     = a_data;
               b_d     = b_data;
               acc_d   = '0;
               step_d  = '0;
               flush_d = 1'b0;
               ovf_d   = 1'b0;
               state_d = CALC;
            end
         end
         CALC: begin
            if (flush_q) begin
               c_d     = res_q;
               flush_d = 1'b0;
               state_d = DONE;
            end else begin
               acc_d  = sum_c;
               ovf_d  = ovf_q | ovf_c;
               step_d = STEP_W'(step_q + STEP_W'(1));
               if (step_q[0]) begin
                  res_d[ELEM_W*32'(c_idx(step_q)) +: ELEM_W] = sum_c;
                  acc_d = '0;
               end
               if (step_q == STEP_W'(NELEM * N - 1)) begin
                  flush_d = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   assign c_data   = c_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;

endmodule
